// File: rtl/riscv_pkg.sv
// Shared core parameters plus the boot loader's frame marker and state encoding.
package riscv_pkg;

  localparam int unsigned ALEN            = 32;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned RAM_MEMORY_SIZE = 1024;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream into little-endian words and writes
// them to instruction memory, keeping the core held until the frame checksum verifies.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned     ALEN      = riscv_pkg::ALEN,
  parameter int unsigned     XLEN      = riscv_pkg::XLEN,
  parameter int unsigned     MEM_WORDS = riscv_pkg::RAM_MEMORY_SIZE,
  parameter logic [ALEN-1:0] BASE_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  output logic            imem_we,
  output logic [ALEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            cpu_hold,
  output logic            load_done,
  output logic            load_error
);

  loader_state_t   r_state;
  logic            r_rx_ready;
  logic            r_imem_we;
  logic [ALEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_hold;
  logic            r_done;
  logic            r_error;
  logic [7:0]      r_chk;
  logic [7:0]      r_cnt_lo;
  logic [15:0]     r_words_rem;
  logic [1:0]      r_idx;
  logic [23:0]     r_buf;

  logic            w_xfer;
  logic [15:0]     w_count;

  assign w_xfer  = rx_valid && r_rx_ready;
  assign w_count = {rx_data, r_cnt_lo};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rx_ready  <= 1'b0;
      r_imem_we   <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_wdata     <= '0;
      r_hold      <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_chk       <= '0;
      r_cnt_lo    <= '0;
      r_words_rem <= '0;
      r_idx       <= '0;
      r_buf       <= '0;
    end else begin
      // Ready is only withdrawn for the single WRITE cycle that follows a word's 4th byte.
      r_rx_ready <= 1'b1;
      r_imem_we  <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (w_xfer && rx_data == LOADER_MAGIC) begin
            r_state <= LEN0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_hold  <= 1'b1;
            r_chk   <= '0;
            r_addr  <= BASE_ADDR;
            r_idx   <= '0;
          end
        end
        LEN0: begin
          if (w_xfer) begin
            r_cnt_lo <= rx_data;
            r_chk    <= r_chk ^ rx_data;
            r_state  <= LEN1;
          end
        end
        LEN1: begin
          if (w_xfer) begin
            r_chk <= r_chk ^ rx_data;
            if (32'(w_count) > MEM_WORDS) begin
              r_state <= ERR;
              r_error <= 1'b1;
            end else if (w_count == '0) begin
              r_state <= CHK;
            end else begin
              r_words_rem <= w_count;
              r_state     <= DATA;
            end
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_chk <= r_chk ^ rx_data;
            if (r_idx == 2'd3) begin
              r_wdata    <= {rx_data, r_buf};
              r_imem_we  <= 1'b1;
              r_rx_ready <= 1'b0;
              r_idx      <= '0;
              r_state    <= WRITE;
            end else begin
              r_buf[{r_idx, 3'b000} +: 8] <= rx_data;
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          r_addr      <= r_addr + ALEN'(4);
          r_words_rem <= r_words_rem - 16'd1;
          r_state     <= (r_words_rem == 16'd1) ? CHK : DATA;
        end
        CHK: begin
          if (w_xfer) begin
            if (rx_data == r_chk) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_error = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader: frames are built from the protocol rules and
// each byte carries its expected consequence, which a per-cycle monitor checks the outputs against.
module tb_imem_loader;

  localparam int unsigned MW   = 16;
  localparam logic [31:0] BASE = 32'h0;

  typedef enum int {E_NONE, E_ARM, E_DONE, E_ERR} eff_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  imem_loader #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Annotation of the byte currently presented: what accepting it must cause.
  eff_t        cur_eff  = E_NONE;
  bit          cur_is4  = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_word = '0;

  // Reference model state.
  bit          m_done = 1'b0, m_err = 1'b0, m_hold = 1'b1;
  bit          m_rst_prev = 1'b0, mon_en = 1'b0;
  bit          want_we = 1'b0;
  logic [31:0] want_addr = '0, want_data = '0;
  int          wr_count = 0;
  logic [31:0] last_addr = '0, last_data = '0;

  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = !(m_rst_prev || want_we);
    if (mon_en) begin
      check("imem_we", imem_we, want_we);
      if (want_we) begin
        check("imem_addr", imem_addr, want_addr);
        check("imem_wdata", imem_wdata, want_data);
      end
      check("rx_ready", rx_ready, exp_ready);
      check("cpu_hold", cpu_hold, m_hold);
      check("load_done", load_done, m_done);
      check("load_error", load_error, m_err);
      if (m_rst_prev) begin
        check("rst_addr", imem_addr, BASE);
        check("rst_wdata", imem_wdata, 32'h0);
      end
    end
    if (imem_we === 1'b1) begin
      wr_count++;
      last_addr = imem_addr;
      last_data = imem_wdata;
    end
    want_we = 1'b0;
    if (!rst) begin
      m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
      m_rst_prev = 1'b1;
      mon_en = 1'b1;
    end else begin
      m_rst_prev = 1'b0;
      if (rx_valid && exp_ready) begin
        case (cur_eff)
          E_ARM:  begin m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1; end
          E_DONE: begin m_done = 1'b1; m_hold = 1'b0; end
          E_ERR:  m_err = 1'b1;
          default: ;
        endcase
        if (cur_is4) begin
          want_we   = 1'b1;
          want_addr = cur_addr;
          want_data = cur_word;
        end
      end
    end
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input eff_t e, input bit is4,
                      input logic [31:0] a, input logic [31:0] w);
    bit acc;
    int t;
    rx_valid = 1'b1; rx_data = b;
    cur_eff = e; cur_is4 = is4; cur_addr = a; cur_word = w;
    acc = 1'b0; t = 0;
    while (!acc && t < 20) begin
      acc = (rx_ready === 1'b1);
      @(posedge clk); #1;
      t++;
    end
    rx_valid = 1'b0; cur_eff = E_NONE; cur_is4 = 1'b0;
    if (!acc) begin
      n_checks++; n_err++;
      $display("FAIL handshake: byte %h not accepted within %0d cycles", b, t);
    end
  endtask

  logic [31:0] pw[$];

  // Sends a frame of n words from pw; chk_force >= 0 replaces the checksum byte, bad corrupts it.
  task automatic send_frame(input int n, input int chk_force, input bit bad, input int gmax);
    logic [7:0]  chk, cb, b;
    logic [15:0] len;
    logic [31:0] w;
    chk = 8'h00;
    len = 16'(n);
    idle($urandom_range(gmax, 0));
    send(8'hA5, E_ARM, 1'b0, '0, '0);
    idle($urandom_range(gmax, 0));
    send(len[7:0], E_NONE, 1'b0, '0, '0);
    chk ^= len[7:0];
    idle($urandom_range(gmax, 0));
    send(len[15:8], (n > int'(MW)) ? E_ERR : E_NONE, 1'b0, '0, '0);
    chk ^= len[15:8];
    if (n > int'(MW)) return;
    for (int i = 0; i < n; i++) begin
      w = pw[i];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        chk ^= b;
        idle($urandom_range(gmax, 0));
        send(b, E_NONE, k == 3, BASE + 32'(4*i), w);
      end
    end
    if (chk_force >= 0) cb = 8'(chk_force);
    else if (bad)       cb = chk ^ 8'($urandom_range(255, 1));
    else                cb = chk;
    idle($urandom_range(gmax, 0));
    send(cb, (cb == chk) ? E_DONE : E_ERR, 1'b0, '0, '0);
  endtask

  task automatic garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send(g, E_NONE, 1'b0, '0, '0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_hold", cpu_hold, 32'd1);
    check("reset_ready", rx_ready, 32'd0);
    rst = 1'b1;
    idle(2);

    // 1-word frame, valid held high
    pw = {32'h00000013};
    wr_count = 0;
    send_frame(1, -1, 1'b0, 0);
    idle(2);
    check("t1_wr_count", wr_count, 32'd1);
    check("t1_addr", last_addr, 32'h0);
    check("t1_data", last_data, 32'h00000013);
    check("t1_done", load_done, 32'd1);
    check("t1_hold", cpu_hold, 32'd0);
    check("t1_error", load_error, 32'd0);

    // 2-word frame
    pw = {32'h00100093, 32'h00200113};
    wr_count = 0;
    send_frame(2, -1, 1'b0, 0);
    idle(2);
    check("t2_wr_count", wr_count, 32'd2);
    check("t2_addr", last_addr, 32'h4);
    check("t2_data", last_data, 32'h00200113);
    check("t2_done", load_done, 32'd1);

    // Bad checksum (correct would be 0x12), then a valid frame clears the error
    pw = {32'h00000013};
    wr_count = 0;
    send_frame(1, 8'h13, 1'b0, 1);
    idle(2);
    check("t3_wr_count", wr_count, 32'd1);
    check("t3_error", load_error, 32'd1);
    check("t3_done", load_done, 32'd0);
    check("t3_hold", cpu_hold, 32'd1);
    send_frame(1, -1, 1'b0, 1);
    idle(2);
    check("t3b_error", load_error, 32'd0);
    check("t3b_done", load_done, 32'd1);

    // Length overflow, then the maximum length
    wr_count = 0;
    send_frame(17, -1, 1'b0, 0);
    idle(3);
    check("t4_wr_count", wr_count, 32'd0);
    check("t4_error", load_error, 32'd1);
    pw = {};
    for (int i = 0; i < 16; i++) pw.push_back($urandom);
    send_frame(16, -1, 1'b0, 1);
    idle(2);
    check("t4b_wr_count", wr_count, 32'd16);
    check("t4b_last_addr", last_addr, 32'h3C);
    check("t4b_done", load_done, 32'd1);

    // Garbage then zero-length frame
    wr_count = 0;
    send(8'h00, E_NONE, 1'b0, '0, '0);
    send(8'hFF, E_NONE, 1'b0, '0, '0);
    send(8'h5A, E_NONE, 1'b0, '0, '0);
    send_frame(0, -1, 1'b0, 0);
    idle(2);
    check("t5_wr_count", wr_count, 32'd0);
    check("t5_done", load_done, 32'd1);

    // Reset mid-payload
    send(8'hA5, E_ARM, 1'b0, '0, '0);
    send(8'h02, E_NONE, 1'b0, '0, '0);
    send(8'h00, E_NONE, 1'b0, '0, '0);
    send(8'h93, E_NONE, 1'b0, '0, '0);
    send(8'h00, E_NONE, 1'b0, '0, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_we", imem_we, 32'd0);
    check("t6_ready", rx_ready, 32'd0);
    check("t6_hold", cpu_hold, 32'd1);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_wdata", imem_wdata, 32'h0);
    check("t6_done", load_done, 32'd0);
    rst = 1'b1;
    idle(1);
    pw = {32'hDEADBEEF, 32'h12345678};
    wr_count = 0;
    send_frame(2, -1, 1'b0, 1);
    idle(2);
    check("t6b_wr_count", wr_count, 32'd2);
    check("t6b_addr", last_addr, 32'h4);
    check("t6b_data", last_data, 32'h12345678);
    check("t6b_done", load_done, 32'd1);

    // Randomized frames with gaps, interleaved garbage, bad checksums and overflows
    for (int f = 0; f < 40; f++) begin
      int n;
      n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(300, MW + 1)) : int'($urandom_range(MW, 0));
      pw = {};
      for (int i = 0; i < n && i < int'(MW); i++) pw.push_back($urandom);
      garbage($urandom_range(2, 0));
      send_frame(n, -1, ($urandom_range(3, 0) == 0), 2);
      idle($urandom_range(2, 0));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
